bounce_emulator: RTL and testbench
==================================

// Module: bounce_emulator
// PURPOSE
//  Stimulus-side counterpart of the debouncer: turns a clean level request into
//  a contact-bounce waveform on `noisy`, with LFSR-randomised toggle count and
//  spacing, then holds the final level for a settle window.
//  Drives debouncer inputs in hardware-in-the-loop tests and on-board self-test.
// PARAMETERS
//  BOUNCE_MAX     8        max bounce pairs per transition; must be a power of 2
//  GAP_MIN        100      min cycles between toggles; must be >= 1
//  GAP_MASK       8'h3F    random extra gap = lfsr[15:8] & GAP_MASK
//  SETTLE_CYCLES  2000000  stable-hold cycles after last toggle; must be >= 1
//  SEED           16'hACE1 LFSR reset value; 0 is replaced by 16'h0001
//  INIT_LEVEL     1'b0     reset level of noisy and settled_level
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  synchronous, active-high reset
//  req_valid      in   1  level-change request valid
//  req_level      in   1  requested final level
//  bounce_en      in   1  1 = bounce, 0 = single clean edge; sampled at accept
//  req_ready      out  1  high only in IDLE; request accepted on valid&ready
//  noisy          out  1  emulated contact output, registered
//  busy           out  1  state != IDLE
//  settled_level  out  1  target level of last accepted request
//  done           out  1  one-cycle pulse when a request completes
// BEHAVIOUR
//  Reset: state=IDLE, noisy=settled_level=INIT_LEVEL, done=0, busy=0,
//   req_ready=1 on the first cycle after reset deasserts, lfsr=SEED (or 1).
//   Reset mid-operation aborts immediately; no done pulse is issued.
//  LFSR: 16-bit Galois, mask 16'hB400, advances every cycle outside reset.
//  FSM: IDLE -> BOUNCE -> SETTLE -> IDLE.
//  IDLE, accept at edge k. settled_level<=req_level at k.
//   - req_level==noisy: no edge on noisy; done=1 in cycle k+1; remain IDLE.
//   - bounce_en=0: noisy<=req_level at k; enter SETTLE.
//   - bounce_en=1: n = 1 + (lfsr[7:0] & (BOUNCE_MAX-1)); toggle count T=2n-1,
//     always odd so the final level equals req_level. First toggle at k;
//     enter BOUNCE with T-1 toggles remaining.
//  BOUNCE: at each toggle, sample gap = GAP_MIN + (lfsr[15:8] & GAP_MASK);
//   next toggle exactly gap cycles later. After the last toggle, enter SETTLE.
//  SETTLE: noisy held constant. done=1 and state=IDLE exactly SETTLE_CYCLES
//   cycles after the last toggle edge. req_ready=1 in the same cycle as done.
//  While busy, req_valid is ignored. Requests are not queued or dropped silently:
//   ready=0 tells the source to hold the request.
//  Counters: 32-bit gap/settle counter, $clog2(2*BOUNCE_MAX) toggle counter,
//   no wrap possible within parameter limits.
//  noisy changes only on toggle edges. It never glitches between toggles.
// TESTING
//  1 Reset held 3 cycles -> noisy=0, settled_level=0, busy=0, done=0; ready=1
//    after release.
//  2 bounce_en=0, req 0->1, SETTLE_CYCLES=10 -> exactly one rising edge at
//    accept+1; done one cycle wide, 10 cycles after that edge.
//  3 bounce_en=1, BOUNCE_MAX=4, GAP_MIN=3, GAP_MASK=3, SETTLE=20, req 1 ->
//    toggle count is odd and <= 7; every spacing is in [3,6]; final noisy=1;
//    done 20 cycles after the last edge.
//  4 req_level == current noisy -> zero edges on noisy, done at accept+1,
//    busy never asserts.
//  5 req_valid pulsed mid-BOUNCE -> ignored, edge sequence unchanged.
//    reset mid-BOUNCE -> noisy=INIT_LEVEL next cycle, no done pulse, ready=1.
//  6 SEED=0 vs SEED=1 with identical stimulus -> identical edge timestamps.
//    Two runs with the same SEED -> bit-identical noisy trace.

Source files
------------

// File: rtl/bounce_emulator.sv
// Contact-bounce generator: converts a clean level request into an odd number of
// LFSR-spaced toggles on noisy, then holds the final level for a settle window.
module bounce_emulator #(
    parameter int unsigned BOUNCE_MAX    = 8,
    parameter int unsigned GAP_MIN       = 100,
    parameter logic [7:0]  GAP_MASK      = 8'h3F,
    parameter int unsigned SETTLE_CYCLES = 2000000,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_level,
    input  logic bounce_en,
    output logic req_ready,
    output logic noisy,
    output logic busy,
    output logic settled_level,
    output logic done
);

    // state    | meaning
    // S_IDLE   | waiting for a request, req_ready high
    // S_BOUNCE | toggling noisy, cnt counts down to the next toggle
    // S_SETTLE | noisy held at final level, cnt counts down to done

    localparam int          TW          = $clog2(2 * BOUNCE_MAX);
    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    localparam logic [7:0]  N_MASK      = 8'(BOUNCE_MAX - 1);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_SETTLE} state_t;

    state_t         state;
    state_t         state_next;
    logic [15:0]    lfsr;
    logic [31:0]    cnt;
    logic [TW-1:0]  toggles_left;
    logic [TW-1:0]  toggles_init;
    logic [31:0]    gap;
    logic           accept;
    logic           same_level;
    logic           cnt_zero;
    logic           last_toggle;
    logic           bounce_start;

    assign accept       = req_valid && (state == S_IDLE);
    assign same_level   = (req_level == noisy);
    assign cnt_zero     = (cnt == 32'd0);
    assign last_toggle  = (toggles_left == TW'(1));
    assign gap          = 32'(GAP_MIN) + 32'(lfsr[15:8] & GAP_MASK);
    // toggles remaining after the first one: 2n-2 with n = 1 + (lfsr & (BOUNCE_MAX-1))
    assign toggles_init = TW'({lfsr[7:0] & N_MASK, 1'b0});
    assign bounce_start = bounce_en && (toggles_init != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && !same_level) begin
                    state_next = bounce_start ? S_BOUNCE : S_SETTLE;
                end
            end
            S_BOUNCE: begin
                if (cnt_zero && last_toggle) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_zero) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr          <= SEED_EFF;
            noisy         <= INIT_LEVEL;
            settled_level <= INIT_LEVEL;
            done          <= 1'b0;
            cnt           <= 32'd0;
            toggles_left  <= '0;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        settled_level <= req_level;
                        if (same_level) begin
                            done <= 1'b1;
                        end else begin
                            // noisy differs from req_level, so the first toggle lands on it
                            noisy <= req_level;
                            if (bounce_start) begin
                                cnt          <= gap - 32'd1;
                                toggles_left <= toggles_init;
                            end else begin
                                cnt <= SETTLE_LOAD;
                            end
                        end
                    end
                end
                S_BOUNCE: begin
                    if (cnt_zero) begin
                        noisy        <= ~noisy;
                        toggles_left <= toggles_left - TW'(1);
                        cnt          <= last_toggle ? SETTLE_LOAD : (gap - 32'd1);
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_zero) begin
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_emulator.sv
// Scoreboard bench for bounce_emulator: the driver queues expected noisy edges and
// done pulses with their cycle numbers; a negedge monitor pops and compares them.
module tb_bounce_emulator;

    localparam int          BM     = 4;
    localparam int          GMIN   = 3;
    localparam logic [7:0]  MASK   = 8'h03;
    localparam int          S      = 10;
    localparam logic [15:0] SEED_M = 16'hACE1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic bounce_en = 1'b0;

    logic req_ready, noisy, busy, settled_level, done;
    logic s0_ready, s0_noisy, s0_busy, s0_settled, s0_done;
    logic s1_ready, s1_noisy, s1_busy, s1_settled, s1_done;
    logic s1b_ready, s1b_noisy, s1b_busy, s1b_settled, s1b_done;

    bounce_emulator #(.BOUNCE_MAX(BM), .GAP_MIN(GMIN), .GAP_MASK(MASK), .SETTLE_CYCLES(S),
                      .SEED(SEED_M), .INIT_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_level(req_level),
        .bounce_en(bounce_en), .req_ready(req_ready), .noisy(noisy), .busy(busy),
        .settled_level(settled_level), .done(done));

    bounce_emulator #(.BOUNCE_MAX(BM), .GAP_MIN(GMIN), .GAP_MASK(MASK), .SETTLE_CYCLES(S),
                      .SEED(16'h0000), .INIT_LEVEL(1'b0)) dut_s0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_level(req_level),
        .bounce_en(bounce_en), .req_ready(s0_ready), .noisy(s0_noisy), .busy(s0_busy),
        .settled_level(s0_settled), .done(s0_done));

    bounce_emulator #(.BOUNCE_MAX(BM), .GAP_MIN(GMIN), .GAP_MASK(MASK), .SETTLE_CYCLES(S),
                      .SEED(16'h0001), .INIT_LEVEL(1'b0)) dut_s1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_level(req_level),
        .bounce_en(bounce_en), .req_ready(s1_ready), .noisy(s1_noisy), .busy(s1_busy),
        .settled_level(s1_settled), .done(s1_done));

    bounce_emulator #(.BOUNCE_MAX(BM), .GAP_MIN(GMIN), .GAP_MASK(MASK), .SETTLE_CYCLES(S),
                      .SEED(16'h0001), .INIT_LEVEL(1'b0)) dut_s1b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_level(req_level),
        .bounce_en(bounce_en), .req_ready(s1b_ready), .noisy(s1b_noisy), .busy(s1b_busy),
        .settled_level(s1b_settled), .done(s1b_done));

    always #5 clk = ~clk;

    typedef struct {
        int   kind;   // 0 = edge on noisy, 1 = done pulse
        int   cyc;
        logic lvl;
    } ev_t;

    ev_t  sb_q[$];
    int   edge_log[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;
    logic [15:0] m_lfsr = SEED_M;
    logic exp_level = 1'b0;
    logic prev_noisy = 1'b0;
    logic s1_prev = 1'b0;
    int   busy_cnt = 0;
    int   seed_diff01 = 0;
    int   seed_diff11 = 0;
    int   s1_edges = 0;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_q  <= reset;
        m_lfsr <= reset ? SEED_M : lstep(m_lfsr);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic lvl);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.lvl  = lvl;
        sb_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic lvl);
        ev_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s actual=event required=none (cycle %0d)",
                     (kind == 1) ? "done" : "edge", cyc);
            return;
        end
        e = sb_q.pop_front();
        check((kind == 1) ? "event_kind_done" : "event_kind_edge", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (kind == 0 && e.kind == 0) check("edge_level", int'(lvl), int'(e.lvl));
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (s0_noisy !== s1_noisy) seed_diff01++;
        if (s1_noisy !== s1b_noisy) seed_diff11++;
        if (s1_noisy !== s1_prev) s1_edges++;
        s1_prev = s1_noisy;
        if (rst_q) begin
            prev_noisy = noisy;
        end else begin
            if (noisy !== prev_noisy) begin
                edge_log.push_back(cyc);
                observe(0, noisy);
            end
            if (done !== 1'b0) observe(1, 1'b0);
            prev_noisy = noisy;
        end
    end

    // Called at posedge+#1 with the DUT idle; the request is accepted at the next edge.
    task automatic issue(input logic lvl, input logic ben);
        int k, n, t, e, gap;
        logic [15:0] lf;
        logic level;
        k  = cyc + 1;
        lf = m_lfsr;
        if (lvl == exp_level) begin
            push(1, k, 1'b0);
        end else if (!ben) begin
            push(0, k, lvl);
            push(1, k + S, 1'b0);
        end else begin
            n = 1 + int'(lf[7:0] & 8'(BM - 1));
            t = 2 * n - 1;
            e = k;
            level = lvl;
            for (int i = 0; i < t; i++) begin
                push(0, e, level);
                level = ~level;
                if (i < t - 1) begin
                    gap = GMIN + int'(lf[15:8] & MASK);
                    for (int j = 0; j < gap; j++) lf = lstep(lf);
                    e += gap;
                end
            end
            push(1, e + S, 1'b0);
        end
        exp_level = lvl;
        req_valid = 1'b1;
        req_level = lvl;
        bounce_en = ben;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        bounce_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_pending"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_noisy", int'(noisy), 0);
        check("reset_settled", int'(settled_level), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;

        issue(1'b1, 1'b0);
        wait_idle("clean_rise");
        check("clean_rise_settled", int'(settled_level), 1);
        issue(1'b0, 1'b0);
        wait_idle("clean_fall");

        busy_cnt = 0;
        issue(1'b0, 1'b1);
        wait_idle("same_level");
        check("same_level_busy_cycles", busy_cnt, 0);

        edge_log.delete();
        issue(1'b1, 1'b1);
        wait_idle("bounce_rise");
        bad = 0;
        for (int i = 1; i < edge_log.size(); i++) begin
            if (edge_log[i] - edge_log[i-1] < 3 || edge_log[i] - edge_log[i-1] > 6) bad++;
        end
        check("bounce_spacing_out_of_range", bad, 0);
        check("bounce_count_odd", edge_log.size() % 2, 1);
        check("bounce_count_le7", int'(edge_log.size() <= 7), 1);
        check("bounce_final_noisy", int'(noisy), 1);
        check("bounce_settled", int'(settled_level), 1);

        issue(1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b1;
        req_level = 1'b1;
        bounce_en = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        bounce_en = 1'b0;
        wait_idle("bounce_fall_ignore_req");
        check("ignore_req_settled", int'(settled_level), 0);

        issue(1'b1, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_level = 1'b0;
        @(negedge clk);
        check("abort_noisy", int'(noisy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ready", int'(req_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_settled", int'(settled_level), 0);
        repeat (60) @(posedge clk);
        #1;

        issue(1'b1, 1'b1);
        wait_idle("post_abort_bounce");

        check("seed0_vs_seed1_trace_diffs", seed_diff01, 0);
        check("seed1_repeat_trace_diffs", seed_diff11, 0);
        check("seed1_has_edges", int'(s1_edges > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
